// File: rtl/fcmp_wb_stage_if.sv
// ============================================================================
// fcmp_wb_stage_if : compare-unit / register-file / CSR signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface fcmp_wb_stage_if #(
  parameter int RD_W  = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_res;
  logic             in_inf;
  logic             in_nan;
  logic [RD_W-1:0]  in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [RD_W-1:0]  out_rd;
  logic             flag_clr;
  logic             flag_nv;
  logic             flag_inf;
  logic [CNT_W-1:0] nan_count;

  modport slave (
    input  in_valid, in_res, in_inf, in_nan, in_rd, out_ready, flag_clr,
    output in_ready, out_valid, out_data, out_rd, flag_nv, flag_inf, nan_count
  );

  modport master (
    output in_valid, in_res, in_inf, in_nan, in_rd, out_ready, flag_clr,
    input  in_ready, out_valid, out_data, out_rd, flag_nv, flag_inf, nan_count
  );
endinterface

`default_nettype wire

// File: rtl/fcmp_wb_stage.sv
// ============================================================================
// fcmp_wb_stage : FP compare writeback FIFO with sticky flags and NaN counter
// Rev 1.0
// ============================================================================
`default_nettype none

module fcmp_wb_stage #(
  parameter int DEPTH = 2,
  parameter int RD_W  = 5,
  parameter int CNT_W = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  fcmp_wb_stage_if.slave bus
);

  localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   C_FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [DEPTH-1:0] res_q;
  logic [RD_W-1:0]  rd_q [DEPTH];
  logic             nv_q, nv_d;
  logic             inf_q, inf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_res_bit;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_unused_res;

  assign w_unused_res = ^bus.in_res[31:1];

  always_comb begin
    w_full     = (occ_q == C_FULL);
    w_empty    = (occ_q == '0);
    w_push     = bus.in_valid && !w_full;
    w_pop      = bus.out_ready && !w_empty;
    // An unordered compare always reports false
    w_res_bit  = bus.in_nan ? 1'b0 : bus.in_res[0];

    wr_ptr_d   = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    occ_d      = occ_q;
    if (w_push && !w_pop) begin
      occ_d = occ_q + (PTR_W + 1)'(1);
    end else if (w_pop && !w_push) begin
      occ_d = occ_q - (PTR_W + 1)'(1);
    end

    // Clear takes effect before a same-cycle push so that event is kept
    nv_d       = bus.flag_clr ? 1'b0 : nv_q;
    inf_d      = bus.flag_clr ? 1'b0 : inf_q;
    w_cnt_base = bus.flag_clr ? '0 : cnt_q;
    cnt_d      = w_cnt_base;
    if (w_push) begin
      nv_d  = nv_d  | bus.in_nan;
      inf_d = inf_d | bus.in_inf;
      if (bus.in_nan && (w_cnt_base != C_CNT_MAX)) begin
        cnt_d = w_cnt_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      res_q    <= '0;
      nv_q     <= 1'b0;
      inf_q    <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      nv_q     <= nv_d;
      inf_q    <= inf_d;
      cnt_q    <= cnt_d;
      if (w_push) begin
        res_q[wr_ptr_q] <= w_res_bit;
        rd_q[wr_ptr_q]  <= bus.in_rd;
      end
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = {31'b0, res_q[rd_ptr_q] & !w_empty};
  assign bus.out_rd    = w_empty ? '0 : rd_q[rd_ptr_q];
  assign bus.flag_nv   = nv_q;
  assign bus.flag_inf  = inf_q;
  assign bus.nan_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fcmp_wb_stage.sv
// ============================================================================
// tb_fcmp_wb_stage : scoreboard bench for fcmp_wb_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fcmp_wb_stage;

  localparam int DEPTH   = 2;
  localparam int RD_W    = 5;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  fcmp_wb_stage_if #(.RD_W(RD_W), .CNT_W(CNT_W)) bus ();

  fcmp_wb_stage #(.DEPTH(DEPTH), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            d;
    logic [RD_W-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  bit   m_nv;
  bit   m_inf;
  int   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic inf, input logic nan,
                       input logic [RD_W-1:0] rd, input logic ordy, input logic clr);
    bus.in_valid  = v;
    bus.in_res    = res;
    bus.in_inf    = inf;
    bus.in_nan    = nan;
    bus.in_rd     = rd;
    bus.out_ready = ordy;
    bus.flag_clr  = clr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: compare against the reference buffer, then apply this cycle's
  // pop (head leaves) and accepted push (new expected entry, flag update).
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      m_nv  = 1'b0;
      m_inf = 1'b0;
      m_cnt = 0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_data",  bus.out_data,       32'd0);
      chk("rst_out_rd",    32'(bus.out_rd),    32'd0);
      chk("rst_flag_nv",   32'(bus.flag_nv),   32'd0);
      chk("rst_flag_inf",  32'(bus.flag_inf),  32'd0);
      chk("rst_nan_count", 32'(bus.nan_count), 32'd0);
    end else begin
      automatic bit   full  = (exp_q.size() == DEPTH);
      automatic exp_t e;
      chk("in_ready",  32'(bus.in_ready),  32'(!full));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("flag_nv",   32'(bus.flag_nv),   32'(m_nv));
      chk("flag_inf",  32'(bus.flag_inf),  32'(m_inf));
      chk("nan_count", 32'(bus.nan_count), 32'(m_cnt));
      if (exp_q.size() != 0) begin
        chk("out_data", bus.out_data,    {31'b0, exp_q[0].d});
        chk("out_rd",   32'(bus.out_rd), 32'(exp_q[0].rd));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (bus.flag_clr) begin
        m_nv  = 1'b0;
        m_inf = 1'b0;
        m_cnt = 0;
      end
      if (bus.in_valid && !full) begin
        e.d  = bus.in_nan ? 1'b0 : bus.in_res[0];
        e.rd = bus.in_rd;
        exp_q.push_back(e);
        m_nv  = m_nv  | bus.in_nan;
        m_inf = m_inf | bus.in_inf;
        m_cnt = (m_cnt + int'(bus.in_nan) > CNT_MAX) ? CNT_MAX : m_cnt + int'(bus.in_nan);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Single entry round trip
    drive(1, 32'd1, 0, 0, 5'd3, 1, 0);
    step();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data",  bus.out_data,       32'd1);
    chk("t1_rd",    32'(bus.out_rd),    32'd3);
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    chk("t1_empty", 32'(bus.out_valid), 32'd0);

    // Fill, blocked push, ordered drain
    drive(1, 32'd1, 0, 0, 5'd5, 0, 0);
    step();
    drive(1, 32'hFFFF_FFFE, 0, 0, 5'd6, 0, 0);
    step();
    chk("t2_full", 32'(bus.in_ready), 32'd0);
    drive(1, 32'd1, 0, 0, 5'd7, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t2_head_rd",   32'(bus.out_rd), 32'd5);
    chk("t2_head_data", bus.out_data,    32'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    chk("t2_second_rd",   32'(bus.out_rd), 32'd6);
    chk("t2_second_data", bus.out_data,    32'd0);
    step();
    chk("t2_drained", 32'(bus.out_valid), 32'd0);

    // NaN forces false and sets sticky invalid
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    drive(1, 32'd1, 0, 1, 5'd9, 1, 0);
    step();
    chk("t3_data",  bus.out_data,        32'd0);
    chk("t3_nv",    32'(bus.flag_nv),    32'd1);
    chk("t3_count", 32'(bus.nan_count),  32'd1);
    drive(1, 32'd1, 0, 0, 5'd10, 1, 0);
    step();
    chk("t3_nv_sticky", 32'(bus.flag_nv), 32'd1);
    chk("t3_rd",        32'(bus.out_rd),  32'd10);
    chk("t3_data2",     bus.out_data,     32'd1);

    // Counter saturation and clear precedence
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    for (int i = 0; i < 300; i++) begin
      drive(1, $urandom, 1'($urandom_range(0, 1)), 1, RD_W'($urandom), 1, 0);
      step();
    end
    chk("t4_sat", 32'(bus.nan_count), 32'(CNT_MAX));
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    chk("t4_clr_count", 32'(bus.nan_count), 32'd0);
    chk("t4_clr_nv",    32'(bus.flag_nv),   32'd0);
    chk("t4_clr_inf",   32'(bus.flag_inf),  32'd0);
    drive(1, 32'd1, 0, 1, 5'd1, 1, 1);
    step();
    chk("t4_clr_push_count", 32'(bus.nan_count), 32'd1);
    chk("t4_clr_push_nv",    32'(bus.flag_nv),   32'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    step();

    // Steady push+pop at occupancy one
    drive(1, 32'd1, 0, 0, 5'd20, 0, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(i & 1), 0, 0, RD_W'(21 + i), 1, 0);
      step();
      chk("t5_valid", 32'(bus.out_valid), 32'd1);
      chk("t5_ready", 32'(bus.in_ready),  32'd1);
    end
    chk("t5_head", 32'(bus.out_rd), 32'd30);
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    chk("t5_drained", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with a full buffer
    drive(1, 32'd1, 1, 1, 5'd11, 0, 0);
    step();
    drive(1, 32'd0, 0, 0, 5'd12, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t6_pre_full", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_ready", 32'(bus.in_ready),  32'd1);
    chk("t6_nv",    32'(bus.flag_nv),   32'd0);
    chk("t6_inf",   32'(bus.flag_inf),  32'd0);
    chk("t6_count", 32'(bus.nan_count), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), RD_W'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (4) step();
    chk("final_empty", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
